// File: rtl/cla_pkg.sv
// Shared types and constants for the byte-serial multi-precision adder.
package cla_pkg;

    localparam int ADDER_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/cla_mp_add_ctrl_if.sv
// Command / operand / result channels of the multi-precision add sequencer.
// master = operand-fetch + result-sink side, slave = the controller.
interface cla_mp_add_ctrl_if #(parameter int LEN_W = 4);
    import cla_pkg::*;

    logic               cmd_valid;
    logic               cmd_ready;
    logic [LEN_W-1:0]   cmd_len;
    logic               cmd_sub;
    logic               cmd_cin;

    logic               op_valid;
    logic               op_ready;
    logic [ADDER_W-1:0] op_a;
    logic [ADDER_W-1:0] op_b;

    logic               res_valid;
    logic               res_ready;
    logic [ADDER_W-1:0] res_sum;
    logic               res_last;
    logic               res_cout;
    logic               res_ovf;

    logic               busy;

    modport master (
        output cmd_valid, cmd_len, cmd_sub, cmd_cin,
        output op_valid, op_a, op_b,
        output res_ready,
        input  cmd_ready, op_ready,
        input  res_valid, res_sum, res_last, res_cout, res_ovf,
        input  busy
    );

    modport slave (
        input  cmd_valid, cmd_len, cmd_sub, cmd_cin,
        input  op_valid, op_a, op_b,
        input  res_ready,
        output cmd_ready, op_ready,
        output res_valid, res_sum, res_last, res_cout, res_ovf,
        output busy
    );

endinterface

// File: rtl/cla_mp_add_ctrl_cla8.sv
// Purely combinational ADDER_W-bit carry-look-ahead adder.
module cla_mp_add_ctrl_cla8
    import cla_pkg::*;
(
    input  logic [ADDER_W-1:0] a,
    input  logic [ADDER_W-1:0] b,
    input  logic               cin,
    output logic [ADDER_W-1:0] sum,
    output logic               cout
);

    logic [ADDER_W-1:0] g;
    logic [ADDER_W-1:0] p;
    logic [ADDER_W:0]   c;
    logic               pp;
    logic               cc;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is the flat OR of generate terms gated by the propagate
    // prefix above them, so no carry waits on the one below it.
    always_comb begin
        c    = '0;
        pp   = 1'b1;
        cc   = 1'b0;
        c[0] = cin;
        for (int i = 0; i < ADDER_W; i++) begin
            pp = 1'b1;
            cc = 1'b0;
            for (int j = i; j >= 0; j--) begin
                cc = cc | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = cc | (pp & cin);
        end
    end

    assign sum  = p ^ c[ADDER_W-1:0];
    assign cout = c[ADDER_W];

endmodule

// File: rtl/cla_mp_add_ctrl.sv
// Byte-serial multi-precision add/subtract sequencer around one shared CLA.
// Operands stream LSB first; the inter-byte carry lives in carry_q.
module cla_mp_add_ctrl
    import cla_pkg::*;
#(
    parameter int LEN_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    cla_mp_add_ctrl_if.slave  bus
);

    state_t             state_q;
    state_t             state_d;
    logic [LEN_W-1:0]   cnt_q;
    logic               sub_q;
    logic               carry_q;

    logic               res_valid_q;
    logic [ADDER_W-1:0] res_sum_q;
    logic               res_last_q;
    logic               res_cout_q;
    logic               res_ovf_q;

    logic               cmd_rdy;
    logic               op_rdy;
    logic               cmd_fire;
    logic               op_fire;
    logic               res_fire;

    logic [ADDER_W-1:0] b_eff;
    logic [ADDER_W-1:0] sum;
    logic               cout;

    // Subtract is A + ~B + 1; the +1 comes from carry_q loaded at command time.
    assign b_eff = sub_q ? ~bus.op_b : bus.op_b;

    cla_mp_add_ctrl_cla8 u_cla (
        .a    (bus.op_a),
        .b    (b_eff),
        .cin  (carry_q),
        .sum  (sum),
        .cout (cout)
    );

    assign res_fire = res_valid_q && bus.res_ready;
    assign cmd_fire = cmd_rdy && bus.cmd_valid;
    assign op_fire  = op_rdy && bus.op_valid;

    // Next-state and handshake readies; cmd_ready is held low while in reset.
    always_comb begin
        state_d = state_q;
        cmd_rdy = 1'b0;
        op_rdy  = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_rdy = rst_n;
                if (bus.cmd_valid && rst_n) state_d = RUN;
            end
            RUN: begin
                op_rdy = !res_valid_q || bus.res_ready;
                if (op_rdy && bus.op_valid && (cnt_q == '0)) state_d = DRAIN;
            end
            DRAIN: begin
                if (res_valid_q && bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Command capture, byte counter, carry chain and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            sub_q       <= 1'b0;
            carry_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_last_q  <= 1'b0;
            res_cout_q  <= 1'b0;
            res_ovf_q   <= 1'b0;
        end else begin
            if (cmd_fire) begin
                cnt_q   <= bus.cmd_len;
                sub_q   <= bus.cmd_sub;
                carry_q <= bus.cmd_sub | bus.cmd_cin;
            end
            if (op_fire) begin
                res_sum_q   <= sum;
                res_cout_q  <= cout;
                res_ovf_q   <= (bus.op_a[ADDER_W-1] == b_eff[ADDER_W-1]) &&
                               (sum[ADDER_W-1] != bus.op_a[ADDER_W-1]);
                res_last_q  <= (cnt_q == '0);
                res_valid_q <= 1'b1;
                carry_q     <= cout;
                if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            end else if (res_fire) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready = cmd_rdy;
    assign bus.op_ready  = op_rdy;
    assign bus.res_valid = res_valid_q;
    assign bus.res_sum   = res_sum_q;
    assign bus.res_last  = res_last_q;
    assign bus.res_cout  = res_cout_q;
    assign bus.res_ovf   = res_ovf_q;
    assign bus.busy      = (state_q != IDLE);

endmodule
